dram_cmd_issuer: RTL and testbench
==================================

# dram_cmd_issuer

Consumer end of the request queue: accepts one aged memory request (parser_out_struct) per transaction from the queue's output/exit_flag pair, decodes bank group, bank, row and column with the global_defs masks/offsets, and sequences the DDR4 command stream (ACT, RD/WR, PRE) under per-command timing counters. Sits between the request queue and the trace/command-logging layer; DRAM command slots are every other CPU_clock (DRAM clock = CPU_clock/2).

## Interface
- TRCD, 24, ACT→CAS delay, DRAM cycles
- TCL, 24, read CAS latency, DRAM cycles
- TCWL, 20, write CAS latency, DRAM cycles
- TBURST, 4, burst length, DRAM cycles
- TWR, 20, write recovery, DRAM cycles
- TRP, 24, precharge period, DRAM cycles
- CPU_clock  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; clock CPU_clock
- req_in  in  parser_out_struct  request (opcode, address used)
- req_valid  in  1  request present this cycle (driven by queue exit_flag)
- req_ready  out  1  issuer idle, can accept
- cmd_valid  out  1  command issued this cycle
- cmd  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE
- cmd_bg  out  2  bank group
- cmd_bank  out  2  bank
- cmd_row  out  15  row
- cmd_col  out  10  column
- done  out  1  one-cycle pulse, transaction complete
- drop_err  out  1  one-cycle pulse, request discarded

## Operation
- States: IDLE, WAIT_SLOT, ACT, WAIT_RCD, CAS, WAIT_DATA, PRE, WAIT_RP.
- Accept when req_valid && req_ready: latch decoded fields and opcode; opcode 0/2 → read, 1 → write.
- Invalid opcode (>2), or req_valid while !req_ready: request discarded, drop_err pulses next cycle, $display error line, state unchanged.
- dram_phase toggles every CPU_clock, 0 in first cycle after reset; cmd_valid only ever high when dram_phase==0.
- Closed-page sequence: ACT → (TRCD) → RD/WR → (TCL+TBURST read; TCWL+TBURST+TWR write) → PRE → (TRP) → done, IDLE.
- Timers count CPU cycles, loaded with 2× parameter; all intervals even, so slot alignment holds.
- cmd_bg/bank/row/col valid only with cmd_valid; 0 otherwise. PRE carries bg/bank, row/col = 0.
- Each issued command printed via $display (time, cmd, bg, bank, row/col).

## Timing
- Reset: req_ready=1, cmd_valid=0, cmd=0, all cmd_* fields=0, done=0, drop_err=0, state IDLE, timers 0.
- Reset mid-operation: sequence abandoned, no PRE issued, outputs to reset values next edge.
- Accept at edge T: req_ready low from T+1; ACT at first dram_phase==0 cycle strictly after T.
- CAS exactly 2·TRCD cycles after ACT; PRE exactly 2·(TCL+TBURST) (read) or 2·(TCWL+TBURST+TWR) (write) after CAS.
- done and req_ready=1 asserted exactly 2·TRP cycles after PRE; new request may be accepted that same cycle.
- Never more than one command per slot; NOP slots have cmd_valid=0.

## Configuration
- OPEN_PAGE_EN defined: 16-entry open-row table (valid+row per bg/bank). Row hit → CAS directly (no ACT); open row miss → PRE, TRP, ACT, TRCD, CAS; closed bank → ACT first. After data phase no PRE: done pulses 2·(data interval) after CAS, row stays open. Table cleared on reset.
- Undefined: closed-page only, every transaction ACT…PRE; no table.

## Test plan
- Reset mid-WAIT_RCD (rst_n low 1 cycle) → next cycle cmd_valid=0, req_ready=1, no PRE; new read then runs full sequence.
- Closed-page read bg=1, bank=2, row=0x1A5, col=0x3F accepted cycle 10 → ACT@12, RD@60 col=0x3F, PRE@116, done@164.
- Closed-page write same address accepted cycle 10 → ACT@12, WR@60, PRE@148, done@196.
- req_valid at cycle 30 during busy → drop_err@31, sequence timing unchanged; opcode 3 at idle → drop_err, req_ready stays 1.
- Acceptance on odd cycle 11 → ACT@12; check cmd_valid never high on odd cycle over 1000 random requests.
- OPEN_PAGE_EN: read row 0x1A5 then read same bank row 0x1A5 → second has no ACT, RD first slot after accept; then row 0x2 → PRE, ACT 48 cycles later, RD 48 after.

Source files
------------

// File: rtl/dram_cmd_issuer_if.sv
// Shared request format, address-decode constants and the queue/issuer/logger handshake bundle.
package global_defs;
    localparam logic [31:0] COL_MASK    = 32'h3FF;
    localparam int          COL_OFFSET  = 0;
    localparam logic [31:0] BANK_MASK   = 32'h3;
    localparam int          BANK_OFFSET = 10;
    localparam logic [31:0] BG_MASK     = 32'h3;
    localparam int          BG_OFFSET   = 12;
    localparam logic [31:0] ROW_MASK    = 32'h7FFF;
    localparam int          ROW_OFFSET  = 14;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    typedef struct packed {
        logic [1:0]  opcode;
        logic [31:0] address;
    } parser_out_struct;
endpackage

interface dram_cmd_issuer_if;
    import global_defs::*;

    parser_out_struct req_in;
    logic             req_valid;
    logic             req_ready;
    logic             cmd_valid;
    logic [2:0]       cmd;
    logic [1:0]       cmd_bg;
    logic [1:0]       cmd_bank;
    logic [14:0]      cmd_row;
    logic [9:0]       cmd_col;
    logic             done;
    logic             drop_err;

    modport master (
        output req_in, req_valid,
        input  req_ready, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, done, drop_err
    );
    modport slave (
        input  req_in, req_valid,
        output req_ready, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, done, drop_err
    );
endinterface

// File: rtl/dram_cmd_issuer.sv
// Decodes one queued request and issues its DDR4 ACT/RD/WR/PRE sequence on even CPU_clock slots.
// Define OPEN_PAGE_EN to keep rows open across transactions via a per-bg/bank open-row table.
module dram_cmd_issuer
    import global_defs::*;
#(
    parameter int TRCD   = 24,
    parameter int TCL    = 24,
    parameter int TCWL   = 20,
    parameter int TBURST = 4,
    parameter int TWR    = 20,
    parameter int TRP    = 24
) (
    input  logic             CPU_clock,
    input  logic             rst_n,
    dram_cmd_issuer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_SLOT, ACT, WAIT_RCD, CAS, WAIT_DATA, PRE, WAIT_RP} state_t;

    // Intervals in CPU cycles; all even so every command lands on a DRAM slot.
    localparam logic [15:0] T_RCD = 16'(2 * TRCD);
    localparam logic [15:0] T_RD  = 16'(2 * (TCL + TBURST));
    localparam logic [15:0] T_WR  = 16'(2 * (TCWL + TBURST + TWR));
    localparam logic [15:0] T_RP  = 16'(2 * TRP);

    state_t      state_q, state_d, first_q, first_d, go;
    logic        phase_q;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  bg_q, bg_d, bank_q, bank_d;
    logic [14:0] row_q, row_d;
    logic [9:0]  col_q, col_d;
    logic        wr_q, wr_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [1:0]  out_bg_q, out_bg_d, out_bank_q, out_bank_d;
    logic [14:0] out_row_q, out_row_d;
    logic [9:0]  out_col_q, out_col_d;
    logic        done_q, done_d, drop_q, drop_d, ready_q;

    logic [1:0]  dec_bg, dec_bank;
    logic [14:0] dec_row;
    logic [9:0]  dec_col;

    assign dec_bg   = 2'((bus.req_in.address >> BG_OFFSET) & BG_MASK);
    assign dec_bank = 2'((bus.req_in.address >> BANK_OFFSET) & BANK_MASK);
    assign dec_row  = 15'((bus.req_in.address >> ROW_OFFSET) & ROW_MASK);
    assign dec_col  = 10'((bus.req_in.address >> COL_OFFSET) & COL_MASK);

`ifdef OPEN_PAGE_EN
    logic [15:0] open_vld_q;
    logic [14:0] open_row_q [16];
    logic [3:0]  dec_idx;

    assign dec_idx = {dec_bg, dec_bank};

    always_comb begin
        if (!open_vld_q[dec_idx])                  go = ACT;
        else if (open_row_q[dec_idx] == dec_row)   go = CAS;
        else                                       go = PRE;
    end

    always_ff @(posedge CPU_clock) begin
        if (!rst_n) begin
            open_vld_q <= '0;
            for (int i = 0; i < 16; i++) open_row_q[i] <= '0;
        end else if (cmd_d == CMD_ACT) begin
            open_vld_q[{bg_d, bank_d}] <= 1'b1;
            open_row_q[{bg_d, bank_d}] <= row_d;
        end
    end
`else
    assign go = ACT;
`endif

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        timer_d    = timer_q;
        bg_d       = bg_q;
        bank_d     = bank_q;
        row_d      = row_q;
        col_d      = col_q;
        wr_d       = wr_q;
        cmd_d      = CMD_NOP;
        out_bg_d   = '0;
        out_bank_d = '0;
        out_row_d  = '0;
        out_col_d  = '0;
        done_d     = 1'b0;
        drop_d     = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                if (bus.req_in.opcode > 2'd2) begin
                    drop_d = 1'b1;
                end else begin
                    bg_d   = dec_bg;
                    bank_d = dec_bank;
                    row_d  = dec_row;
                    col_d  = dec_col;
                    wr_d   = (bus.req_in.opcode == 2'd1);
                    // Odd cycle now means the next cycle is a command slot.
                    if (phase_q) begin
                        state_d = go;
                    end else begin
                        state_d = WAIT_SLOT;
                        first_d = go;
                    end
                end
            end
            WAIT_SLOT: state_d = first_q;
            ACT: begin state_d = WAIT_RCD;  timer_d = timer_q - 16'd1; end
            CAS: begin state_d = WAIT_DATA; timer_d = timer_q - 16'd1; end
            PRE: begin state_d = WAIT_RP;   timer_d = timer_q - 16'd1; end
            WAIT_RCD:
                if (timer_q == 16'd1) state_d = CAS;
                else                  timer_d = timer_q - 16'd1;
            WAIT_DATA:
                if (timer_q == 16'd1) begin
`ifdef OPEN_PAGE_EN
                    state_d = IDLE;
                    done_d  = 1'b1;
`else
                    state_d = PRE;
`endif
                end else timer_d = timer_q - 16'd1;
            WAIT_RP:
                if (timer_q == 16'd1) begin
`ifdef OPEN_PAGE_EN
                    state_d = ACT;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else timer_d = timer_q - 16'd1;
            default: state_d = IDLE;
        endcase

        if (bus.req_valid && !ready_q) drop_d = 1'b1;

        // Command states are entered for exactly one cycle, so entry is the issue point.
        case (state_d)
            ACT: begin
                cmd_d      = CMD_ACT;
                timer_d    = T_RCD;
                out_bg_d   = bg_d;
                out_bank_d = bank_d;
                out_row_d  = row_d;
            end
            CAS: begin
                cmd_d      = wr_d ? CMD_WR : CMD_RD;
                timer_d    = wr_d ? T_WR : T_RD;
                out_bg_d   = bg_d;
                out_bank_d = bank_d;
                out_col_d  = col_d;
            end
            PRE: begin
                cmd_d      = CMD_PRE;
                timer_d    = T_RP;
                out_bg_d   = bg_d;
                out_bank_d = bank_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CPU_clock) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            first_q    <= IDLE;
            phase_q    <= 1'b0;
            timer_q    <= '0;
            bg_q       <= '0;
            bank_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wr_q       <= 1'b0;
            cmd_q      <= CMD_NOP;
            out_bg_q   <= '0;
            out_bank_q <= '0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            phase_q    <= ~phase_q;
            timer_q    <= timer_d;
            bg_q       <= bg_d;
            bank_q     <= bank_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wr_q       <= wr_d;
            cmd_q      <= cmd_d;
            out_bg_q   <= out_bg_d;
            out_bank_q <= out_bank_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            ready_q    <= (state_d == IDLE);
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.cmd_valid = (cmd_q != CMD_NOP);
    assign bus.cmd       = cmd_q;
    assign bus.cmd_bg    = out_bg_q;
    assign bus.cmd_bank  = out_bank_q;
    assign bus.cmd_row   = out_row_q;
    assign bus.cmd_col   = out_col_q;
    assign bus.done      = done_q;
    assign bus.drop_err  = drop_q;
endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Directed bench for dram_cmd_issuer: cycle 0 is the first cycle after the reset edge (DRAM slot).
module tb_dram_cmd_issuer;
    import global_defs::*;

    logic CPU_clock = 1'b0;
    logic rst_n     = 1'b0;
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    logic quiet     = 1'b0;

    dram_cmd_issuer_if bus();

    dram_cmd_issuer dut (.CPU_clock(CPU_clock), .rst_n(rst_n), .bus(bus));

    always #5 CPU_clock = ~CPU_clock;

    // bg=1 bank=2 row=0x1A5 col=0x3F, and the same bank with row 0x2
    localparam logic [31:0] ADDR_A = 32'h0069_583F;
    localparam logic [31:0] ADDR_B = 32'h0000_983F;

    int act_cnt = 0, cas_cnt = 0, pre_cnt = 0, done_cnt = 0, drop_cnt = 0;
    int odd_cnt = 0, nz_cnt = 0, bad_cnt = 0;
    int act_cyc = 0, cas_cyc = 0, pre_cyc = 0, done_cyc = 0, drop_cyc = 0;
    logic [2:0]  cas_cmd = '0;
    logic [1:0]  act_bg = '0, act_bank = '0, cas_bg = '0, cas_bank = '0, pre_bg = '0, pre_bank = '0;
    logic [14:0] act_row = '0, cas_row = '0, pre_row = '0;
    logic [9:0]  act_col = '0, cas_col = '0, pre_col = '0;
    logic        done_rdy = 1'b0;

    always @(negedge CPU_clock) begin
        if (!rst_n) begin
            act_cnt <= 0; cas_cnt <= 0; pre_cnt <= 0; done_cnt <= 0; drop_cnt <= 0;
            odd_cnt <= 0; nz_cnt <= 0; bad_cnt <= 0;
        end else begin
            if (bus.cmd_valid) begin
                if (cyc % 2 == 1) odd_cnt <= odd_cnt + 1;
                if (!quiet)
                    $display("%0t cmd=%0d bg=%0d bank=%0d row=%h col=%h", $time, bus.cmd,
                             bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col);
                case (bus.cmd)
                    CMD_ACT: begin
                        act_cnt <= act_cnt + 1; act_cyc <= cyc;
                        act_bg <= bus.cmd_bg; act_bank <= bus.cmd_bank;
                        act_row <= bus.cmd_row; act_col <= bus.cmd_col;
                    end
                    CMD_RD, CMD_WR: begin
                        cas_cnt <= cas_cnt + 1; cas_cyc <= cyc; cas_cmd <= bus.cmd;
                        cas_bg <= bus.cmd_bg; cas_bank <= bus.cmd_bank;
                        cas_row <= bus.cmd_row; cas_col <= bus.cmd_col;
                    end
                    CMD_PRE: begin
                        pre_cnt <= pre_cnt + 1; pre_cyc <= cyc;
                        pre_bg <= bus.cmd_bg; pre_bank <= bus.cmd_bank;
                        pre_row <= bus.cmd_row; pre_col <= bus.cmd_col;
                    end
                    default: bad_cnt <= bad_cnt + 1;
                endcase
            end else if ({bus.cmd, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col} != '0) begin
                nz_cnt <= nz_cnt + 1;
            end
            if (bus.done) begin
                done_cnt <= done_cnt + 1; done_cyc <= cyc; done_rdy <= bus.req_ready;
            end
            if (bus.drop_err) begin
                drop_cnt <= drop_cnt + 1; drop_cyc <= cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CPU_clock);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] addr);
        bus.req_in    = '{opcode: op, address: addr};
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] op;
        int rdy_cyc, acc_exp, drop_exp;
        bus.req_valid = 1'b0;
        bus.req_in    = '0;
        rst_n = 1'b0;
        tick();
        do_reset();

        chk("rst_ready", bus.req_ready, 1);
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_cmd", bus.cmd, 0);
        chk("rst_fields", {bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col}, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_drop", bus.drop_err, 0);

`ifdef OPEN_PAGE_EN
        wait_until(10); send(2'd0, ADDR_A);
        wait_until(118);
        chk("op1_act_cyc", act_cyc, 12);
        chk("op1_rd_cyc", cas_cyc, 60);
        chk("op1_done_cyc", done_cyc, 116);
        chk("op1_pre_cnt", pre_cnt, 0);
        wait_until(120); send(2'd0, ADDR_A);
        wait_until(180);
        chk("op2_rd_cyc", cas_cyc, 122);
        chk("op2_act_cnt", act_cnt, 1);
        chk("op2_done_cyc", done_cyc, 178);
        send(2'd0, ADDR_B);
        wait_until(340);
        chk("op3_pre_cyc", pre_cyc, 182);
        chk("op3_pre_bank", {pre_bg, pre_bank}, 4'b0110);
        chk("op3_act_cyc", act_cyc, 230);
        chk("op3_act_row", act_row, 15'h2);
        chk("op3_rd_cyc", cas_cyc, 278);
        chk("op3_done_cyc", done_cyc, 334);
        chk("op_odd", odd_cnt, 0);
`else
        // Closed-page read with a request arriving while busy.
        wait_until(10); send(2'd0, ADDR_A);
        chk("rd_ready_low", bus.req_ready, 0);
        wait_until(30); send(2'd0, ADDR_A);
        chk("rd_drop_pulse", bus.drop_err, 1);
        wait_until(170);
        chk("rd_act_cyc", act_cyc, 12);
        chk("rd_act_addr", {act_bg, act_bank, act_row, act_col}, {2'd1, 2'd2, 15'h1A5, 10'h0});
        chk("rd_cas_cyc", cas_cyc, 60);
        chk("rd_cas_cmd", cas_cmd, CMD_RD);
        chk("rd_cas_addr", {cas_bg, cas_bank, cas_row, cas_col}, {2'd1, 2'd2, 15'h0, 10'h3F});
        chk("rd_pre_cyc", pre_cyc, 116);
        chk("rd_pre_addr", {pre_bg, pre_bank, pre_row, pre_col}, {2'd1, 2'd2, 15'h0, 10'h0});
        chk("rd_done_cyc", done_cyc, 164);
        chk("rd_done_ready", done_rdy, 1);
        chk("rd_drop_cyc", drop_cyc, 31);
        chk("rd_cmd_count", {act_cnt[7:0], cas_cnt[7:0], pre_cnt[7:0]}, 24'h010101);
        chk("rd_idle_fields", nz_cnt, 0);

        // Closed-page write, then an invalid opcode at idle.
        do_reset();
        wait_until(10); send(2'd1, ADDR_A);
        wait_until(200);
        chk("wr_act_cyc", act_cyc, 12);
        chk("wr_cas_cyc", cas_cyc, 60);
        chk("wr_cas_cmd", cas_cmd, CMD_WR);
        chk("wr_pre_cyc", pre_cyc, 148);
        chk("wr_done_cyc", done_cyc, 196);
        wait_until(198); send(2'd3, ADDR_A);
        chk("bad_op_drop", bus.drop_err, 1);
        chk("bad_op_ready", bus.req_ready, 1);
        wait_until(210);
        chk("bad_op_no_cmd", act_cnt, 1);

        // Reset during WAIT_RCD, then a read accepted on an odd cycle.
        do_reset();
        wait_until(10); send(2'd0, ADDR_A);
        wait_until(30);
        do_reset();
        chk("mid_rst_cmd_valid", bus.cmd_valid, 0);
        chk("mid_rst_ready", bus.req_ready, 1);
        wait_until(11);
        chk("mid_rst_no_pre", pre_cnt, 0);
        send(2'd0, ADDR_A);
        wait_until(170);
        chk("odd_act_cyc", act_cyc, 12);
        chk("odd_cas_cyc", cas_cyc, 60);
        chk("odd_pre_cyc", pre_cyc, 116);
        chk("odd_done_cyc", done_cyc, 164);

        // Random traffic against a timing model of when the issuer is idle again.
        do_reset();
        quiet    = 1'b1;
        rdy_cyc  = 0;
        acc_exp  = 0;
        drop_exp = 0;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 30)) tick();
            op = 2'($urandom_range(0, 3));
            if (op != 2'd3 && cyc >= rdy_cyc) begin
                acc_exp++;
                rdy_cyc = cyc + ((cyc % 2 == 1) ? 1 : 2) + 48 + ((op == 2'd1) ? 88 : 56) + 48;
            end else begin
                drop_exp++;
            end
            send(op, $urandom);
        end
        repeat (300) tick();
        chk("rnd_odd_slot", odd_cnt, 0);
        chk("rnd_idle_fields", nz_cnt, 0);
        chk("rnd_bad_cmd", bad_cnt, 0);
        chk("rnd_done_cnt", done_cnt, acc_exp);
        chk("rnd_act_cnt", act_cnt, acc_exp);
        chk("rnd_drop_cnt", drop_cnt, drop_exp);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
